// File: rtl/avalon_crypto_mc_interface.sv
// Avalon-MM register file that shares one AES decryption core among NUM_CH channels.
// Each channel owns key/input/output blocks plus START/DONE; a round-robin scheduler feeds the core.
module avalon_crypto_mc_interface #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int NUM_CH      = 2,
  parameter int STRIDE      = 16,
  parameter int ADDR_W      = 6
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          AVL_CS,
  input  logic                          AVL_READ,
  input  logic                          AVL_WRITE,
  input  logic [ADDR_W-1:0]             AVL_ADDR,
  input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
  input  logic [DATA_W-1:0]             AVL_WRITEDATA,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic [DATA_W-1:0]             EXPORT_DATA,
  output logic                          CORE_START,
  output logic [BLOCK_WORDS*DATA_W-1:0] CORE_KEY,
  output logic [BLOCK_WORDS*DATA_W-1:0] CORE_MSG_IN,
  input  logic                          CORE_DONE,
  input  logic [BLOCK_WORDS*DATA_W-1:0] CORE_MSG_OUT
);

  localparam int BW   = BLOCK_WORDS;
  localparam int NB   = DATA_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GLB  = NUM_CH * STRIDE;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_key     [NUM_CH][BW];
  logic [DATA_W-1:0]  r_msg_in  [NUM_CH][BW];
  logic [DATA_W-1:0]  r_msg_out [NUM_CH][BW];
  logic [NUM_CH-1:0]  r_start;
  logic [NUM_CH-1:0]  r_done;
  logic [NUM_CH-1:0]  r_pending;
  logic [CH_W-1:0]    r_act;
  logic [CH_W-1:0]    r_last;
  logic [DATA_W-1:0]  r_export_sel;
  logic [DATA_W-1:0]  r_rdata;
  logic [CH_W-1:0]    w_pick;
  logic               w_pick_vld;
  logic [NUM_CH-1:0]  w_in_service;
  logic [DATA_W-1:0]  w_rd_val;
  logic [DATA_W-1:0]  w_status;
  logic               w_wr;
  logic               w_rd;

  assign w_wr         = AVL_CS && AVL_WRITE;
  assign w_rd         = AVL_CS && AVL_READ;
  assign AVL_READDATA = r_rdata;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [NB-1:0]     be);
    f_merge = old_v;
    for (int b = 0; b < NB; b++)
      if (be[b]) f_merge[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  // Round-robin: the pending channel at the smallest distance past last_served wins.
  always_comb begin : rr_pick
    int w_best_dist;
    w_best_dist = NUM_CH;
    w_pick      = r_last;
    w_pick_vld  = |r_pending;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_pending[c] && (((c + NUM_CH - 1 - int'(r_last)) % NUM_CH) < w_best_dist)) begin
        w_best_dist = (c + NUM_CH - 1 - int'(r_last)) % NUM_CH;
        w_pick      = CH_W'(c);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_in_service[c] = (r_state != S_IDLE) && (r_act == CH_W'(c));
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    CORE_START   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_next_state = S_ISSUE;
      S_ISSUE: begin
        CORE_START   = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT:  if (CORE_DONE) w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the block arrays are reset too, since software may read them before ever writing.
      for (int c = 0; c < NUM_CH; c++) begin
        for (int w = 0; w < BW; w++) begin
          r_key[c][w]     <= '0;
          r_msg_in[c][w]  <= '0;
          r_msg_out[c][w] <= '0;
        end
      end
      r_start      <= '0;
      r_done       <= '0;
      r_pending    <= '0;
      r_act        <= '0;
      r_last       <= CH_W'(NUM_CH - 1);
      r_export_sel <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_rd) r_rdata <= w_rd_val;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int w = 0; w < BW; w++) begin
          if (w_wr && !w_in_service[c] && AVL_ADDR == ADDR_W'(c*STRIDE + w))
            r_key[c][w] <= f_merge(r_key[c][w], AVL_WRITEDATA, AVL_BYTE_EN);
          if (w_wr && !w_in_service[c] && AVL_ADDR == ADDR_W'(c*STRIDE + BW + w))
            r_msg_in[c][w] <= f_merge(r_msg_in[c][w], AVL_WRITEDATA, AVL_BYTE_EN);
          if (r_state == S_WAIT && CORE_DONE && r_act == CH_W'(c))
            r_msg_out[c][w] <= CORE_MSG_OUT[(BW-1-w)*DATA_W +: DATA_W];
        end
        if (w_wr && AVL_BYTE_EN[0] && AVL_ADDR == ADDR_W'(c*STRIDE + 3*BW)) begin
          r_start[c] <= AVL_WRITEDATA[0];
          if (AVL_WRITEDATA[0] && !r_pending[c] && !w_in_service[c]) begin
            r_pending[c] <= 1'b1;
            r_done[c]    <= 1'b0;
          end
        end
        if (r_state == S_ISSUE && r_act == CH_W'(c)) r_pending[c] <= 1'b0;
        if (r_state == S_WB && r_act == CH_W'(c))    r_done[c]    <= 1'b1;
      end
      if (w_wr && AVL_ADDR == ADDR_W'(GLB))
        r_export_sel <= f_merge(r_export_sel, AVL_WRITEDATA, AVL_BYTE_EN);
      if (r_state == S_IDLE && w_pick_vld) r_act  <= w_pick;
      if (r_state == S_WB)                 r_last <= r_act;
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[0]         = (r_state != S_IDLE);
    w_status[4 +: CH_W] = r_act;
    w_status[8 +: NUM_CH] = r_pending;
  end

  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int w = 0; w < BW; w++) begin
        if (AVL_ADDR == ADDR_W'(c*STRIDE + w))        w_rd_val = r_key[c][w];
        if (AVL_ADDR == ADDR_W'(c*STRIDE + BW + w))   w_rd_val = r_msg_in[c][w];
        if (AVL_ADDR == ADDR_W'(c*STRIDE + 2*BW + w)) w_rd_val = r_msg_out[c][w];
      end
      if (AVL_ADDR == ADDR_W'(c*STRIDE + 3*BW))     w_rd_val = DATA_W'(r_start[c]);
      if (AVL_ADDR == ADDR_W'(c*STRIDE + 3*BW + 1)) w_rd_val = DATA_W'(r_done[c]);
    end
    if (AVL_ADDR == ADDR_W'(GLB))     w_rd_val = r_export_sel;
    if (AVL_ADDR == ADDR_W'(GLB + 1)) w_rd_val = w_status;
  end

  // Core operands follow the latched active channel; its KEY/MSG_IN are write-protected while in service.
  always_comb begin
    CORE_KEY    = '0;
    CORE_MSG_IN = '0;
    for (int w = 0; w < BW; w++) begin
      CORE_KEY[(BW-1-w)*DATA_W +: DATA_W]    = r_key[r_act][w];
      CORE_MSG_IN[(BW-1-w)*DATA_W +: DATA_W] = r_msg_in[r_act][w];
    end
  end

  always_comb begin
    EXPORT_DATA = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < BW; w++)
        if (r_export_sel == DATA_W'(c*BW + w)) EXPORT_DATA = r_msg_out[c][w];
  end

endmodule

// File: doc/avalon_crypto_mc_interface.md
Name: avalon_crypto_mc_interface

Overview:
- Parametrised Avalon-MM slave register file that fronts one shared AES decryption core for NUM_CH independent software channels.
- Each channel has its own key and input block registers, an output block register, a START register and a DONE register.
- A round-robin scheduler dispatches pending channels to the core one at a time and writes each result back to its channel.
- A selectable output word is driven on EXPORT_DATA for the hex displays; the block sits inside the Qsys SoC as a custom component.

Parameters:
- DATA_W, 32, Avalon data width; must be a multiple of 8.
- BLOCK_WORDS, 4, DATA_W-wide words per key and per block (4 words x 32 bits = 128 bits).
- NUM_CH, 2, number of channels; allowed range 1..8.
- STRIDE, 16, words per channel window; must be a power of 2 and >= 3*BLOCK_WORDS+2.
- ADDR_W, 6, word address width; must satisfy 2^ADDR_W >= (NUM_CH+1)*STRIDE.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- AVL_CS  in  1  chip select.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_BYTE_EN  in  DATA_W/8  byte enables.
- AVL_WRITEDATA  in  DATA_W  write data.
- AVL_READDATA  out  DATA_W  read data; read latency is 1.
- EXPORT_DATA  out  DATA_W  output word selected by EXPORT_SEL.
- CORE_START  out  1  one-cycle start pulse to the core.
- CORE_KEY  out  BLOCK_WORDS*DATA_W  key of the active channel; word 0 occupies the MSBs.
- CORE_MSG_IN  out  BLOCK_WORDS*DATA_W  input block of the active channel.
- CORE_DONE  in  1  one-cycle completion pulse from the core.
- CORE_MSG_OUT  in  BLOCK_WORDS*DATA_W  result; valid in the cycle CORE_DONE is high.

Behaviour:
- Address map: channel window base is c*STRIDE.
  - Offsets 0..BW-1: KEY (read/write).
  - Offsets BW..2BW-1: MSG_IN (read/write).
  - Offsets 2BW..3BW-1: MSG_OUT (read-only).
  - Offset 3BW: START (read/write, bit 0 only).
  - Offset 3BW+1: DONE (read-only, bit 0).
  - Global region at NUM_CH*STRIDE: +0 EXPORT_SEL (read/write); +1 STATUS (read-only).
  - STATUS layout: bit 0 = busy, bits 7:4 = active channel, bits 15:8 = pending mask.
  - Unmapped addresses read 0; writes to them are ignored.
- Register writes:
  - Take effect when AVL_CS && AVL_WRITE, one byte lane per AVL_BYTE_EN bit.
  - Writes to KEY or MSG_IN of the channel currently in service (ISSUE, WAIT or WB) are dropped.
  - Writes to read-only registers are dropped.
- Reads: AVL_CS && AVL_READ registers the addressed value into AVL_READDATA on the next edge. Otherwise AVL_READDATA holds its previous value.
- START handling:
  - Writing bit 0 = 1 to an idle channel sets pending[c] and clears DONE[c].
  - The same write while the channel is pending or in service is ignored; no re-issue.
  - Writing 0 clears the START register only; it never cancels a pending request.
- Scheduler FSM, states IDLE, ISSUE, WAIT, WB:
  - IDLE: if any pending bit is set, choose the first pending channel after last_served in round-robin order; latch it as act; go to ISSUE.
  - ISSUE: CORE_START = 1 for exactly one cycle; clear pending[act]; go to WAIT.
  - WAIT: hold until CORE_DONE; capture CORE_MSG_OUT into MSG_OUT[act]; go to WB.
  - WB: set DONE[act]; last_served <= act; go to IDLE.
  - Dispatch latency: START write edge -> CORE_START high 2 cycles later when the core is idle.
- CORE_KEY and CORE_MSG_IN are driven from channel act and stay stable from ISSUE through WB.
- CORE_DONE outside WAIT is ignored. This covers a stale completion arriving after a reset.
- A read of DONE or MSG_OUT in the same cycle as the writeback update returns the pre-update value.
- EXPORT_DATA = MSG_OUT word (EXPORT_SEL mod BW) of channel (EXPORT_SEL / BW). It is 0 when EXPORT_SEL >= NUM_CH*BW. It is combinational from the registers.
- Reset:
  - All registers, pending, DONE, act, last_served (reset value NUM_CH-1) and EXPORT_SEL go to 0 except last_served.
  - AVL_READDATA = 0, CORE_START = 0, FSM goes to IDLE.
  - Reset during WAIT abandons the operation; no DONE is set.

Test Plan:
- Reset, then read every mapped address -> all read 0; EXPORT_DATA = 0; STATUS = 0.
- Ch0: write KEY word0 = 0x00010203 with BYTE_EN = 0b0101, then read -> 0x00010003; write START = 1 -> CORE_START pulses 2 cycles later. Core returns 0xDAECAB2B... -> MSG_OUT reads it; DONE = 1.
- Write START = 1 to ch0 and ch1 in the same cycle-pair while idle -> ch0 served first, then ch1. Repeat -> ch1's turn order respects last_served.
- During ch0 WAIT: write ch0 KEY word1 = 0xFFFFFFFF -> the value is unchanged and CORE_KEY is stable. A second START = 1 -> exactly one CORE_START.
- Assert RESET in WAIT, then pulse CORE_DONE after reset -> DONE and MSG_OUT stay 0; FSM stays IDLE.
- EXPORT_SEL = 5 with NUM_CH = 2 -> EXPORT_DATA = ch1 MSG_OUT word1. EXPORT_SEL = 8 -> EXPORT_DATA = 0.
